// File: rtl/psum_accumulator.sv
// Sums AccLen consecutive PE partial sums into one element and queues finished elements in a small FIFO.
// Optional build macro PSUM_ACC_SAT_EN: saturate each add to the signed range instead of wrapping.
module psum_accumulator #(
    parameter int DataWidth   = 32,
    parameter int AccLen      = 9,
    parameter int AccLenWidth = 4,
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic                   clk_en,
    input  logic                   DataInValid,
    input  logic [DataWidth-1:0]   DataIn,
    output logic                   DataInRdy,
    output logic                   DataOutValid,
    output logic [DataWidth-1:0]   DataOut,
    input  logic                   DataOutRdy,
    output logic [AccLenWidth-1:0] BeatCount,
    output logic [BufferWidth:0]   Level
);

    localparam logic [AccLenWidth-1:0] LastBeat  = AccLenWidth'(AccLen - 1);
    localparam logic [BufferWidth:0]   FullLevel = (BufferWidth + 1)'(BufferSize);

    logic [DataWidth-1:0]   acc;
    logic [DataWidth-1:0]   sum;
    logic [DataWidth-1:0]   mem [BufferSize];
    logic [BufferWidth-1:0] wr_ptr;
    logic [BufferWidth-1:0] rd_ptr;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   last_beat;
    logic                   push;

    assign DataInRdy    = clk_en && (Level != FullLevel);
    assign DataOutValid = clk_en && (Level != '0);
    assign DataOut      = (Level != '0) ? mem[rd_ptr] : '0;

    assign in_xfer   = DataInValid && DataInRdy;
    assign out_xfer  = DataOutValid && DataOutRdy;
    assign last_beat = (BeatCount == LastBeat);
    assign push      = in_xfer && last_beat;

`ifdef PSUM_ACC_SAT_EN
    logic [DataWidth:0] wide_sum;

    // One extra bit exposes signed overflow; clamp toward the sign of the true result.
    always_comb begin
        wide_sum = {acc[DataWidth-1], acc} + {DataIn[DataWidth-1], DataIn};
        sum      = wide_sum[DataWidth-1:0];
        if (wide_sum[DataWidth] != wide_sum[DataWidth-1]) begin
            sum = wide_sum[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                      : {1'b0, {(DataWidth-1){1'b1}}};
        end
    end
`else
    always_comb begin
        sum = acc + DataIn;
    end
`endif

    always_ff @(posedge clk) begin
        if (sclr) begin
            acc       <= '0;
            BeatCount <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            Level     <= '0;
        end else begin
            if (in_xfer) begin
                if (last_beat) begin
                    acc       <= '0;
                    BeatCount <= '0;
                end else begin
                    acc       <= sum;
                    BeatCount <= BeatCount + 1'b1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (out_xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Pointers wrap naturally because BufferSize is a power of two.
            unique case ({push, out_xfer})
                2'b10:   Level <= Level + 1'b1;
                2'b01:   Level <= Level - 1'b1;
                default: Level <= Level;
            endcase
        end
    end

    // Storage is not cleared on sclr; DataOut is masked by Level instead.
    always_ff @(posedge clk) begin
        if (push && !sclr) begin
            mem[wr_ptr] <= sum;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised and directed bench for psum_accumulator; a list-of-beats reference model feeds a scoreboard queue.
// Build with +define+PSUM_ACC_SAT_EN to check the saturating variant.
module tb_psum_accumulator;

    localparam int AccLen = 9;
    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        sclr;
    logic        clk_en;
    logic        DataInValid;
    logic [31:0] DataIn;
    logic        DataInRdy;
    logic        DataOutValid;
    logic [31:0] DataOut;
    logic        DataOutRdy;
    logic [3:0]  BeatCount;
    logic [2:0]  Level;

    int n_checks = 0;
    int n_pass   = 0;
    logic checking = 1'b0;

    logic [31:0] beats[$];
    logic [31:0] exp_q[$];
    logic        cap_acc = 1'b0;
    logic        cap_rst = 1'b0;
    logic [31:0] cap_data = '0;

    psum_accumulator dut (
        .clk          (clk),
        .sclr         (sclr),
        .clk_en       (clk_en),
        .DataInValid  (DataInValid),
        .DataIn       (DataIn),
        .DataInRdy    (DataInRdy),
        .DataOutValid (DataOutValid),
        .DataOut      (DataOut),
        .DataOutRdy   (DataOutRdy),
        .BeatCount    (BeatCount),
        .Level        (Level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Element value from the list of its beats, added in arrival order.
    function automatic logic [31:0] ref_sum(input logic [31:0] b[$]);
        longint s = 0;
        foreach (b[i]) begin
            s = s + longint'($signed(b[i]));
`ifdef PSUM_ACC_SAT_EN
            if (s > SMax) s = SMax;
            else if (s < SMin) s = SMin;
`else
            s = longint'($signed(s[31:0]));
`endif
        end
        return s[31:0];
    endfunction

    always @(negedge clk) begin
        cap_rst  <= checking && sclr;
        cap_acc  <= checking && !sclr && clk_en && DataInValid && DataInRdy;
        cap_data <= DataIn;
    end

    always @(posedge clk) begin
        if (cap_rst) begin
            beats.delete();
            exp_q.delete();
        end else if (cap_acc) begin
            beats.push_back(cap_data);
            if (beats.size() == AccLen) begin
                exp_q.push_back(ref_sum(beats));
                beats.delete();
            end
        end
    end

    // Monitor: state checks every cycle, then scoreboard pop on each output transfer.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("level", 64'(Level), 64'(exp_q.size()));
            checkOutput("beat_count", 64'(BeatCount), 64'(beats.size()));
            checkOutput("out_valid", 64'(DataOutValid), 64'(clk_en && exp_q.size() != 0));
            checkOutput("in_rdy", 64'(DataInRdy), 64'(clk_en && exp_q.size() != 4));
            if (exp_q.size() == 0) begin
                checkOutput("empty_out", 64'(DataOut), 64'd0);
            end
            if (DataOutValid && DataOutRdy && !sclr) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL sb_underflow: got 0x%0h expected no output", DataOut);
                end else begin
                    checkOutput("sb_data", 64'(DataOut), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                                 input logic e, input logic s);
        DataInValid = v;
        DataIn      = d;
        DataOutRdy  = r;
        clk_en      = e;
        sclr        = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        DataInValid = 1'b0;
        DataIn      = '0;
        DataOutRdy  = 1'b0;
        clk_en      = 1'b1;
        sclr        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sclr     = 1'b0;
        checking = 1'b1;
        checkOutput("rst_level", 64'(Level), 64'd0);
        checkOutput("rst_out", 64'(DataOut), 64'd0);
        checkOutput("rst_valid", 64'(DataOutValid), 64'd0);
        checkOutput("rst_beat", 64'(BeatCount), 64'd0);
        checkOutput("rst_rdy", 64'(DataInRdy), 64'd1);

        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
        checkOutput("seq_valid", 64'(DataOutValid), 64'd1);
        checkOutput("seq_sum", 64'(DataOut), 64'd45);
        checkOutput("seq_level", 64'(Level), 64'd1);
        checkOutput("seq_beat", 64'(BeatCount), 64'd0);
        drain(1);

        // Fill: only four elements fit, the rest of the valid beats stall.
        for (int i = 0; i < 45; i++) applyStimulus(1'b1, 32'd1, 1'b0, 1'b1, 1'b0);
        checkOutput("full_level", 64'(Level), 64'd4);
        checkOutput("full_rdy", 64'(DataInRdy), 64'd0);
        applyStimulus(1'b1, 32'd1, 1'b1, 1'b1, 1'b0);
        checkOutput("pop_level", 64'(Level), 64'd3);
        checkOutput("pop_beat", 64'(BeatCount), 64'd0);
        checkOutput("pop_rdy", 64'(DataInRdy), 64'd1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'd1, 1'b0, 1'b1, 1'b0);
        checkOutput("refill_level", 64'(Level), 64'd4);
        drain(5);
        checkOutput("drained_level", 64'(Level), 64'd0);

        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`ifdef PSUM_ACC_SAT_EN
        checkOutput("ovf_sum", 64'(DataOut), 64'h7FFF_FFFF);
`else
        checkOutput("ovf_sum", 64'(DataOut), 64'h7FFF_FFF7);
`endif
        drain(1);

        for (int i = 0; i < 22; i++) applyStimulus(1'b1, 32'd3, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_clr_level", 64'(Level), 64'd2);
        checkOutput("pre_clr_beat", 64'(BeatCount), 64'd4);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_level", 64'(Level), 64'd0);
        checkOutput("clr_beat", 64'(BeatCount), 64'd0);
        checkOutput("clr_out", 64'(DataOut), 64'd0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'd2, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_sum", 64'(DataOut), 64'd18);
        drain(1);

        for (int i = 10; i <= 13; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd99, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_beat", 64'(BeatCount), 64'd4);
        checkOutput("stall_rdy", 64'(DataInRdy), 64'd0);
        for (int i = 14; i <= 18; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b1, 1'b0);
        checkOutput("stall_sum", 64'(DataOut), 64'd126);
        drain(1);

        // Random traffic: mostly small signed values, some full-range ones to exercise overflow.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = 32'($urandom_range(0, 1000)) - 32'd500;
            applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);
        end
        drain(8);
        checkOutput("final_level", 64'(Level), 64'd0);

        checking = 1'b0;
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream stage of the single-PE custom instruction: it consumes the PE's partial-sum output stream (O_Out / O_OutValid / O_OutRdy) and adds AccLen consecutive partial sums into one output element. It queues finished sums in a small FIFO that the Nios II "get result" instruction drains. This replaces the direct O_Out to result path with per-element accumulation and buffering.

## Interface
- DataWidth, 32, width of partial sums and results
- AccLen, 9, partial sums summed per output element (≥1)
- AccLenWidth, 4, width of beat counter (2^AccLenWidth ≥ AccLen)
- BufferWidth, 2, FIFO address width
- BufferSize, 4, FIFO depth (= 2^BufferWidth)

Ports:
- clk  in  1  clock; all state updates on rising edge
- sclr  in  1  synchronous, active-high reset; overrides clk_en
- clk_en  in  1  clock enable; low freezes all state and blocks transfers
- DataInValid  in  1  partial sum valid (from PE O_OutValid)
- DataIn  in  DataWidth  partial sum, two's complement
- DataInRdy  out  1  accepts DataIn this cycle (to PE O_OutRdy)
- DataOutValid  out  1  FIFO head valid
- DataOut  out  DataWidth  FIFO head; 0 when empty
- DataOutRdy  in  1  consumer pops head (instruction n==4)
- BeatCount  out  AccLenWidth  partial sums already absorbed into current element
- Level  out  BufferWidth+1  FIFO occupancy, 0..BufferSize

## Operation
- Input transfer: DataInValid & DataInRdy & clk_en.
- DataInRdy = clk_en & (Level != BufferSize). Never depends on DataInValid.
- Accumulator register acc and counter BeatCount.
- On input transfer with BeatCount < AccLen-1: acc <= acc + DataIn; BeatCount++.
- On input transfer with BeatCount == AccLen-1: push acc + DataIn into FIFO; acc <= 0; BeatCount <= 0.
- AccLen==1: every accepted beat is pushed unchanged.
- Arithmetic: signed add, result truncated to DataWidth (wraps mod 2^DataWidth).
- FIFO: circular, write/read pointers BufferWidth bits, wrap BufferSize-1 -> 0; Level tracked explicitly.
- Output transfer (pop): DataOutValid & DataOutRdy. DataOutValid = clk_en & (Level != 0).
- Simultaneous push and pop: both occur; Level unchanged; pointers both advance.
- Full: no push is possible because DataInRdy=0; there is no bypass. Partial accumulation in acc is retained.
- Empty: DataOut = 0, DataOutValid = 0; DataOutRdy ignored.
- clk_en low: acc, BeatCount, pointers, and Level hold; DataInRdy = DataOutValid = 0.
- sclr: acc=0, BeatCount=0, pointers=0, Level=0. FIFO contents need not be cleared, but DataOut must read 0.

## Timing
- Reset values after sclr: DataOutValid 0, DataOut 0, BeatCount 0, Level 0, DataInRdy = clk_en.
- Element latency: the final beat is accepted at edge N; DataOutValid=1 with the sum from edge N, in the cycle after N (1 cycle).
- Throughput: 1 partial sum per cycle while not full; 1 pop per cycle.
- DataOut/DataOutValid are combinational from FIFO state only, so they are stable within a cycle for the instruction's done/result path.
- sclr mid-element discards the partial sum and all queued results. It takes effect at that edge even when clk_en=0.

## Configuration
- PSUM_ACC_SAT_EN defined: the add saturates to the signed range; positive overflow gives 0x7FFFFFFF and negative gives 0x80000000 (for DataWidth=32). Saturation is evaluated per add, so later adds start from the clamped value.
- Undefined: wrap-around add as in Operation. No other behaviour differs.

## Test plan
- AccLen=9: feed 1..9 continuously with DataOutRdy=0 -> one cycle after the 9th accept, DataOutValid=1, DataOut=45, Level=1, BeatCount=0.
- Fill: 5 elements of nine 1s with DataOutRdy=0 -> Level=4, DataInRdy=0 while the 5th element is still accumulating; after one pop, DataInRdy=1; pops yield 9,9,9,9,9 in order.
- Simultaneous event: Level=4, pop during the cycle a final beat would be accepted -> the beat is stalled one cycle and then accepted; Level 4->3->4.
- Overflow: nine beats of 0x7FFFFFFF -> without the macro DataOut=0x7FFFFFF7; with PSUM_ACC_SAT_EN DataOut=0x7FFFFFFF.
- sclr after 4 beats and with Level=2 -> next cycle BeatCount=0, Level=0, DataOut=0; the next 9 beats of 2 yield 18.
- clk_en=0 for 3 cycles mid-stream with DataInValid=1 -> no transfers, state frozen; the result equals the same stream without the stall.
